alu_arith_sched: RTL and testbench
==================================

ALU_ARITH_SCHED -- requirements
Module: alu_arith_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0, req1  input  1 each  operation request from requester 0/1; held high with operands stable until the matching grant.
REQ-005 a0, b0, a1, b1  input  3 each  operands from requester 0/1.
REQ-006 s0, s1  input  2 each  opcode: 00 A+B, 01 A-B (A+~B+1), 10 A+1, 11 A+0.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands are captured on this cycle's edge.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer accepts result when res_valid and res_ready are both high at a rising edge.
REQ-010 res_data  output  3  registered arithmetic result.
REQ-011 res_carry, res_neg, res_ovf  output  1 each  registered carry-out, sign bit (res_data[2]), signed overflow.
REQ-012 res_id  output  1  index of the requester owning the current result.
REQ-013 busy  output  1  high in every state other than IDLE.
REQ-014 sticky_ovf  output  1  set when an accepted result has res_ovf=1.
REQ-015 clr_ovf  input  1  synchronous clear of sticky_ovf.

Function
REQ-016 The block SHALL instantiate the team's existing 3-bit arithmetic unit as the single shared datapath, fed only from internal operand registers.
REQ-017 FSM states SHALL be IDLE, GRANT, EXEC, RESP.
REQ-018 IDLE: if any req is high, choose a winner by round-robin and go to GRANT; otherwise stay.
REQ-019 Round-robin: the winner is the requester not served last; with only one request it wins regardless; after reset requester 0 has priority.
REQ-020 GRANT: assert the winner's gnt for exactly one cycle, latch its a, b, s and id into internal registers, go to EXEC.
REQ-021 EXEC: register the datapath outputs into res_data/res_carry/res_neg/res_ovf, go to RESP.
REQ-022 RESP: res_valid=1 and all res_* outputs held stable until acceptance; on acceptance deassert res_valid next cycle, record res_id as last-served, go to IDLE.
REQ-023 Minimum request-to-res_valid latency SHALL be 3 cycles (IDLE sample, GRANT, EXEC); throughput at most one operation per 4 cycles.
REQ-024 Arithmetic SHALL be modulo 8; res_carry is bit 3 of the 4-bit sum A+summand+carry_in, carry_in=1 for opcodes 01 and 10.
REQ-025 res_ovf SHALL be 1 only when A[2] equals summand[2] and res_data[2] differs from A[2] (summand = B, ~B, 000, 000 per opcode).
REQ-026 Requests arriving in GRANT, EXEC or RESP SHALL be ignored until the return to IDLE; no request is lost if held.
REQ-027 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-028 sticky_ovf: set on acceptance of a result with res_ovf=1; cleared by clr_ovf; simultaneous set and clear results in set.

Reset
REQ-029 On rst_n low, immediately: state IDLE, gnt0=gnt1=0, res_valid=0, res_data=000, res_carry=res_neg=res_ovf=0, res_id=0, busy=0, sticky_ovf=0, last-served=1 (requester 0 priority).
REQ-030 Reset asserted mid-operation SHALL abort it with no result delivered; after release the block waits in IDLE for fresh requests.

Verification
REQ-031 req0 only, a0=3, b0=2, s0=00, res_ready=1 -> gnt0 pulses once, res_valid 3 cycles after req sampled, res_data=101, res_neg=1, res_ovf=1, res_carry=0, res_id=0, sticky_ovf=1 after acceptance.
REQ-032 req1 only, a1=2, b1=3, s1=01 -> res_data=111, res_carry=0, res_neg=1, res_ovf=0, res_id=1.
REQ-033 req0 and req1 held continuously from reset -> grants alternate 0,1,0,1; never both in a cycle.
REQ-034 res_ready held low 5 cycles in RESP -> res_valid and res_* stable all 5 cycles; new req ignored; accepted on first ready cycle.
REQ-035 a0=3, s0=10 -> res_data=100, res_ovf=1; a0=7, s0=10 -> res_data=000, res_carry=1, res_ovf=0.
REQ-036 rst_n pulsed low during EXEC -> all outputs at reset values at once, no res_valid; clr_ovf and an overflow acceptance in the same cycle leave sticky_ovf=1.

Source files
------------

// File: rtl/alu_arith_sched.sv
// alu_arith_sched: shares one 3-bit arithmetic unit between two requesters.
// A round-robin arbiter picks a requester and pulses its grant for one cycle
// while capturing its operands. The shared unit then computes, and the
// registered result is held in RESP until the consumer accepts it.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   req0/req1            requests, held with stable operands until granted
//   a0,b0,s0 / a1,b1,s1  operands and opcode per requester
//                        (00 A+B, 01 A-B, 10 A+1, 11 A+0)
//   gnt0/gnt1            one-cycle grant pulses, never both high
//   res_valid/res_ready  result handshake
//   res_data             3-bit result
//   res_carry            carry-out of the result
//   res_neg              sign bit of the result
//   res_ovf              signed overflow of the result
//   res_id               requester that owns the result
//   busy                 high whenever the scheduler is not idle
//   sticky_ovf           set when an accepted result overflowed
//   clr_ovf              synchronous clear of sticky_ovf

// alu_arith3: the shared 3-bit arithmetic unit.
// It adds A, a summand chosen by the opcode, and a carry-in.
// Ports: a, b, op in; y, carry, neg, ovf out.
module alu_arith3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic [1:0] op,
  output logic [2:0] y,
  output logic       carry,
  output logic       neg,
  output logic       ovf
);
  logic [2:0] summand;
  logic       cin;
  logic [3:0] sum;

  always_comb begin
    summand = 3'b000;
    cin     = 1'b0;
    case (op)
      2'b00: summand = b;
      2'b01: begin summand = ~b; cin = 1'b1; end
      2'b10: cin = 1'b1;
      default: summand = 3'b000;
    endcase
    sum   = {1'b0, a} + {1'b0, summand} + {3'b000, cin};
    y     = sum[2:0];
    carry = sum[3];
    neg   = sum[2];
    // Overflow: both addends share a sign and the result's sign differs.
    ovf   = (a[2] == summand[2]) && (sum[2] != a[2]);
  end
endmodule

module alu_arith_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] a0,
  input  logic [2:0] b0,
  input  logic [2:0] a1,
  input  logic [2:0] b1,
  input  logic [1:0] s0,
  input  logic [1:0] s1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [2:0] res_data,
  output logic       res_carry,
  output logic       res_neg,
  output logic       res_ovf,
  output logic       res_id,
  output logic       busy,
  output logic       sticky_ovf,
  input  logic       clr_ovf
);
  typedef enum logic [1:0] {IDLE, GRANT, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic       win_q, win_d;
  logic       last_q, last_d;
  logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [2:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0] op_s_q, op_s_d;
  logic       res_id_q, res_id_d;
  logic [2:0] res_data_q, res_data_d;
  logic       res_carry_q, res_carry_d;
  logic       res_neg_q, res_neg_d;
  logic       res_ovf_q, res_ovf_d;
  logic       res_valid_q, res_valid_d;
  logic       sticky_q, sticky_d;

  logic       win_sel;
  logic       accept;
  logic [2:0] alu_y;
  logic       alu_carry, alu_neg, alu_ovf;

  // The datapath only ever sees the captured operand registers.
  alu_arith3 u_alu (
    .a    (op_a_q),
    .b    (op_b_q),
    .op   (op_s_q),
    .y    (alu_y),
    .carry(alu_carry),
    .neg  (alu_neg),
    .ovf  (alu_ovf)
  );

  // With both requesting, serve the one not served last; otherwise the
  // lone requester wins.
  assign win_sel = (req0 && req1) ? ~last_q : req1;
  assign accept  = (state_q == RESP) && res_ready;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_s_d      = op_s_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_neg_d   = res_neg_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d   = win_sel;
          gnt0_d  = ~win_sel;
          gnt1_d  = win_sel;
          state_d = GRANT;
        end
      end
      GRANT: begin
        op_a_d   = win_q ? a1 : a0;
        op_b_d   = win_q ? b1 : b0;
        op_s_d   = win_q ? s1 : s0;
        res_id_d = win_q;
        state_d  = EXEC;
      end
      EXEC: begin
        res_data_d  = alu_y;
        res_carry_d = alu_carry;
        res_neg_d   = alu_neg;
        res_ovf_d   = alu_ovf;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          last_d      = res_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Setting on an overflowing acceptance takes precedence over clr_ovf.
  always_comb begin
    sticky_d = sticky_q;
    if (accept && res_ovf_q) sticky_d = 1'b1;
    else if (clr_ovf)        sticky_d = 1'b0;
  end

  // Reset leaves requester 1 as last served so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      op_a_q      <= 3'b000;
      op_b_q      <= 3'b000;
      op_s_q      <= 2'b00;
      res_id_q    <= 1'b0;
      res_data_q  <= 3'b000;
      res_carry_q <= 1'b0;
      res_neg_q   <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_s_q      <= op_s_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_neg_q   <= res_neg_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      sticky_q    <= sticky_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_carry  = res_carry_q;
  assign res_neg    = res_neg_q;
  assign res_ovf    = res_ovf_q;
  assign res_id     = res_id_q;
  assign busy       = (state_q != IDLE);
  assign sticky_ovf = sticky_q;
endmodule

// File: tb/tb_alu_arith_sched.sv
// tb_alu_arith_sched: directed bench for alu_arith_sched with hand-computed
// expected results, round-robin ordering, backpressure and reset abort.
module tb_alu_arith_sched;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] a0, b0, a1, b1;
  logic [1:0] s0, s1;
  logic       gnt0, gnt1;
  logic       res_valid, res_ready;
  logic [2:0] res_data;
  logic       res_carry, res_neg, res_ovf, res_id;
  logic       busy, sticky_ovf, clr_ovf;

  int vec_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  alu_arith_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .s0        (s0),
    .s1        (s1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_neg   (res_neg),
    .res_ovf   (res_ovf),
    .res_id    (res_id),
    .busy      (busy),
    .sticky_ovf(sticky_ovf),
    .clr_ovf   (clr_ovf)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Raise a request with its operands on one requester.
  task automatic applyStimulus(input int who, input logic [2:0] a, input logic [2:0] b,
                               input logic [1:0] s);
    if (who == 0) begin
      a0 = a; b0 = b; s0 = s; req0 = 1'b1;
    end else begin
      a1 = a; b1 = b; s1 = s; req1 = 1'b1;
    end
  endtask

  // Run one operation with res_ready high, checking grant, latency and result.
  task automatic runOp(input int who, input logic [2:0] a, input logic [2:0] b,
                       input logic [1:0] s, input int exp_data, input int exp_carry,
                       input int exp_neg, input int exp_ovf);
    int gnt_at;
    int valid_at;
    gnt_at   = -1;
    valid_at = -1;
    res_ready = 1'b1;
    applyStimulus(who, a, b, s);
    for (int c = 1; c <= 8 && valid_at < 0; c++) begin
      @(negedge clk);
      if (gnt_at < 0 && (gnt0 || gnt1)) begin
        gnt_at = c;
        checkOutput("gnt_owner", gnt1, who);
        req0 = 1'b0;
        req1 = 1'b0;
      end
      if (res_valid) valid_at = c;
    end
    checkOutput("gnt_latency", gnt_at, 1);
    checkOutput("valid_latency", valid_at, 3);
    checkOutput("res_data", res_data, exp_data);
    checkOutput("res_carry", res_carry, exp_carry);
    checkOutput("res_neg", res_neg, exp_neg);
    checkOutput("res_ovf", res_ovf, exp_ovf);
    checkOutput("res_id", res_id, who);
    @(negedge clk);
    checkOutput("valid_drop", res_valid, 0);
    checkOutput("idle_busy", busy, 0);
  endtask

  initial begin
    int valid_at;
    int grants_seen;
    int both_count;
    int grant_order [4];

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = 3'd0; b0 = 3'd0; a1 = 3'd0; b1 = 3'd0; s0 = 2'd0; s1 = 2'd0;
    res_ready = 1'b1; clr_ovf = 1'b0;

    // Reset state.
    #1;
    checkOutput("rst_gnt0", gnt0, 0);
    checkOutput("rst_gnt1", gnt1, 0);
    checkOutput("rst_valid", res_valid, 0);
    checkOutput("rst_data", res_data, 0);
    checkOutput("rst_id", res_id, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sticky", sticky_ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 3+2 overflows into 101.
    runOp(0, 3'd3, 3'd2, 2'b00, 5, 0, 1, 1);
    checkOutput("sticky_set", sticky_ovf, 1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checkOutput("sticky_clr", sticky_ovf, 0);

    // Increment cases.
    runOp(0, 3'd3, 3'd0, 2'b10, 4, 0, 1, 1);
    runOp(0, 3'd7, 3'd5, 2'b10, 0, 1, 0, 0);
    // Pass-through A+0.
    runOp(1, 3'd6, 3'd3, 2'b11, 6, 0, 1, 0);

    // Backpressure: 1+1 held in RESP while a new request arrives.
    res_ready = 1'b0;
    applyStimulus(0, 3'd1, 3'd1, 2'b00);
    valid_at = -1;
    for (int c = 1; c <= 8 && valid_at < 0; c++) begin
      @(negedge clk);
      if (gnt0) req0 = 1'b0;
      if (res_valid) valid_at = c;
    end
    checkOutput("bp_valid_latency", valid_at, 3);
    applyStimulus(1, 3'd2, 3'd3, 2'b01);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_valid_held", res_valid, 1);
      checkOutput("bp_data_held", res_data, 2);
      checkOutput("bp_no_gnt", gnt0 | gnt1, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_accept", res_valid, 0);
    @(negedge clk);
    checkOutput("bp_held_req_gnt1", gnt1, 1);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("sub_valid", res_valid, 1);
    checkOutput("sub_data", res_data, 7);
    checkOutput("sub_carry", res_carry, 0);
    checkOutput("sub_neg", res_neg, 1);
    checkOutput("sub_ovf", res_ovf, 0);
    checkOutput("sub_id", res_id, 1);
    @(negedge clk);

    // Both requesters held from reset: grants alternate starting at 0.
    rst_n = 1'b0;
    applyStimulus(0, 3'd1, 3'd2, 2'b00);
    applyStimulus(1, 3'd4, 3'd1, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    grants_seen = 0;
    both_count  = 0;
    for (int c = 0; c < 40 && grants_seen < 4; c++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both_count++;
      if (gnt0 || gnt1) begin
        grant_order[grants_seen] = gnt1;
        grants_seen++;
      end
    end
    checkOutput("rr_count", grants_seen, 4);
    checkOutput("rr_both", both_count, 0);
    for (int i = 0; i < 4; i++) checkOutput("rr_order", grant_order[i], i % 2);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (6) @(negedge clk);

    // Make sticky set, then reset in EXEC must clear everything.
    runOp(0, 3'd3, 3'd2, 2'b00, 5, 0, 1, 1);
    applyStimulus(0, 3'd3, 3'd3, 2'b00);
    @(negedge clk);
    checkOutput("abort_gnt", gnt0, 1);
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", res_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_data", res_data, 0);
    checkOutput("abort_sticky", sticky_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("abort_no_result", res_valid | busy, 0);
    end

    // Overflow acceptance with clr_ovf high: set wins.
    clr_ovf = 1'b1;
    runOp(0, 3'd3, 3'd2, 2'b00, 5, 0, 1, 1);
    checkOutput("sticky_set_wins", sticky_ovf, 1);
    clr_ovf = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule
